// File: rtl/minutos_if.sv
// Signal bundle between the minutes stage and its neighbours in the display chain.
// The master drives the carry-in, the mode switches and KEY; the slave returns the carry and digits.
interface minutos_if;
  logic       clockIN;
  logic       SW16;
  logic       SW17;
  logic       KEY;
  logic       clockOUT;
  logic [6:0] segU;
  logic [6:0] segT;

  modport master (
    output clockIN, SW16, SW17, KEY,
    input  clockOUT, segU, segT
  );

  modport slave (
    input  clockIN, SW16, SW17, KEY,
    output clockOUT, segU, segT
  );
endinterface

// File: rtl/minutos.sv
// Minutes stage: a BCD 00-59 counter with run, clear and set modes.
// It drives two registered active-low 7-segment digits and a one-cycle hour carry.
module minutos (
  input  logic      clock,
  input  logic      reset,
  minutos_if.slave  bus
);

  typedef enum logic [1:0] {ModeRun, ModeClear, ModeSet} mode_e;

  mode_e      mode;
  logic [3:0] units;
  logic [2:0] tens;
  logic       key_s1, key_s2, key_prev;
  logic       carry;
  logic [6:0] seg_u, seg_t;
  logic       key_fall;
  logic       step;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Only the source selected by the registered mode may advance the count.
  always_comb begin
    key_fall = key_prev & ~key_s2;
    step     = 1'b0;
    if (mode == ModeRun) begin
      step = bus.clockIN;
    end else if (mode == ModeSet) begin
      step = key_fall;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode     <= ModeRun;
      units    <= 4'd0;
      tens     <= 3'd0;
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_prev <= 1'b1;
      carry    <= 1'b0;
      seg_u    <= 7'b0000001;
      seg_t    <= 7'b0000001;
    end else begin
      if (bus.SW16) begin
        mode <= ModeSet;
      end else if (bus.SW17) begin
        mode <= ModeClear;
      end else begin
        mode <= ModeRun;
      end

      key_s1   <= bus.KEY;
      key_s2   <= key_s1;
      key_prev <= key_s2;

      // Digits show the count as it stood before this edge: one cycle of display lag.
      seg_u <= seg_decode(units);
      seg_t <= seg_decode({1'b0, tens});

      carry <= 1'b0;
      if (mode == ModeClear) begin
        units <= 4'd0;
        tens  <= 3'd0;
      end else if (step) begin
        if (units == 4'd9) begin
          units <= 4'd0;
          if (tens == 3'd5) begin
            tens  <= 3'd0;
            carry <= (mode == ModeRun);
          end else begin
            tens <= tens + 3'd1;
          end
        end else begin
          units <= units + 4'd1;
        end
      end
    end
  end

  assign bus.clockOUT = carry;
  assign bus.segU     = seg_u;
  assign bus.segT     = seg_t;

endmodule
